// File: rtl/hyperbus_pkg.sv
// Shared HyperBus definitions: burst-controller state encoding and the word/mask
// widths derived from the DQ width, also used by the leader controller.
package hyperbus_pkg;

    localparam logic [2:0] S_IDLE  = 3'b001;
    localparam logic [2:0] S_BURST = 3'b010;
    localparam logic [2:0] S_GAP   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_BURST = S_BURST,
        ST_GAP   = S_GAP
    } hb_state_e;

    localparam int HB_WIDTH = 8;

    // One HyperBus word is two DQ transfers (DDR).
    function automatic int word_w(input int width);
        return 2 * width;
    endfunction

    function automatic int mask_w(input int width);
        return (2 * width) / 8;
    endfunction

endpackage

// File: rtl/hyperbus_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, search starting at a
// rotating pointer that moves past the winner on each advance strobe.
module hyperbus_rr_arbiter #(
    parameter int NCHAN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCHAN-1:0] req,
    input  logic             advance,
    output logic [NCHAN-1:0] grant
);

    localparam int PW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt_ptr;
    logic          found;
    int            idx;

    always_comb begin
        grant   = '0;
        nxt_ptr = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NCHAN; i++) begin
            idx = (int'(ptr) + i) % NCHAN;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                nxt_ptr    = PW'((idx + 1) % NCHAN);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= nxt_ptr;
    end

endmodule

// File: rtl/hyperbus_burst_ctrl.sv
// Multi-channel burst front end for the HyperBus leader controller.
// Define HBUS_CSM_SPLIT_EN to split transfers into MAX_BURST-word bursts (tCSM limit).
module hyperbus_burst_ctrl
    import hyperbus_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ADDR_LENGTH = 32,
    parameter int NCHAN       = 2,
    parameter int LEN_WIDTH   = 8,
    parameter int MAX_BURST   = 64,
    parameter int GAP_COUNT   = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NCHAN-1:0]                ch_req_i,
    input  logic [NCHAN-1:0]                ch_we_i,
    input  logic [NCHAN*ADDR_LENGTH-1:0]    ch_adr_i,
    input  logic [NCHAN*LEN_WIDTH-1:0]      ch_len_i,
    input  logic [NCHAN*2*WIDTH-1:0]        ch_wdat_i,
    input  logic [NCHAN*(2*WIDTH/8)-1:0]    ch_wmask_i,
    output logic [NCHAN-1:0]                ch_grant_o,
    output logic [NCHAN-1:0]                ch_wack_o,
    output logic [2*WIDTH-1:0]              ch_rdat_o,
    output logic [NCHAN-1:0]                ch_rvalid_o,
    output logic [NCHAN-1:0]                ch_done_o,
    output logic [ADDR_LENGTH-1:0]          mem_adr_o,
    output logic [2*WIDTH-1:0]              mem_dat_o,
    output logic [2*WIDTH/8-1:0]            mem_mask_o,
    input  logic [2*WIDTH-1:0]              mem_dat_i,
    input  logic                            mem_ready_i,
    input  logic                            mem_valid_i,
    output logic                            mem_wrq_o,
    output logic                            mem_rrq_o
);

    localparam int WW = word_w(WIDTH);
    localparam int MW = mask_w(WIDTH);
    localparam int GW = (GAP_COUNT > 1) ? $clog2(GAP_COUNT) : 1;

    if (NCHAN < 1 || NCHAN > 8 || MAX_BURST < 1 || GAP_COUNT < 1) begin : g_bad_cfg
        $error("hyperbus_burst_ctrl: unsupported parameter set");
    end

    function automatic logic [LEN_WIDTH-1:0] burst_len(input logic [LEN_WIDTH-1:0] rem);
`ifdef HBUS_CSM_SPLIT_EN
        if (int'(rem) > MAX_BURST)
            return LEN_WIDTH'(MAX_BURST);
        return rem;
`else
        return rem;
`endif
    endfunction

    hb_state_e                  state;
    logic [NCHAN-1:0]           grant;
    logic [NCHAN-1:0]           done;
    logic                       we;
    logic [ADDR_LENGTH-1:0]     cur_adr;
    logic [ADDR_LENGTH-1:0]     mem_adr;
    logic [LEN_WIDTH-1:0]       remain;
    logic [LEN_WIDTH-1:0]       beats;
    logic [GW-1:0]              gap_cnt;
    logic                       wrq;
    logic                       rrq;

    logic [NCHAN-1:0]           arb_grant;
    logic                       arb_adv;
    logic [ADDR_LENGTH-1:0]     sel_adr;
    logic [LEN_WIDTH-1:0]       sel_len;
    logic                       sel_we;
    logic [WW-1:0]              cur_wdat;
    logic [MW-1:0]              cur_wmask;
    logic                       beat;

    // The done cycle itself never arbitrates, giving the one-cycle IDLE dwell.
    assign arb_adv = (state == ST_IDLE) && (done == '0) && (|ch_req_i);

    hyperbus_rr_arbiter #(.NCHAN(NCHAN)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (ch_req_i),
        .advance (arb_adv),
        .grant   (arb_grant)
    );

    always_comb begin
        sel_adr   = '0;
        sel_len   = '0;
        sel_we    = 1'b0;
        cur_wdat  = '0;
        cur_wmask = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (arb_grant[i]) begin
                sel_adr = ch_adr_i[i*ADDR_LENGTH +: ADDR_LENGTH];
                sel_len = ch_len_i[i*LEN_WIDTH +: LEN_WIDTH];
                sel_we  = ch_we_i[i];
            end
            if (grant[i]) begin
                cur_wdat  = ch_wdat_i[i*WW +: WW];
                cur_wmask = ch_wmask_i[i*MW +: MW];
            end
        end
    end

    assign beat = (wrq & mem_ready_i) | (rrq & mem_valid_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            done    <= '0;
            we      <= 1'b0;
            cur_adr <= '0;
            mem_adr <= '0;
            remain  <= '0;
            beats   <= '0;
            gap_cnt <= '0;
            wrq     <= 1'b0;
            rrq     <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_adv) begin
                        grant   <= arb_grant;
                        we      <= sel_we;
                        cur_adr <= sel_adr;
                        mem_adr <= sel_adr;
                        remain  <= sel_len;
                        beats   <= burst_len(sel_len);
                        wrq     <= sel_we && (sel_len != '0);
                        rrq     <= !sel_we && (sel_len != '0);
                        state   <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // remain is only zero here for a zero-length transfer.
                    if (remain == '0) begin
                        done  <= grant;
                        grant <= '0;
                        state <= ST_IDLE;
                    end else if (beat) begin
                        cur_adr <= cur_adr + ADDR_LENGTH'(1);
                        remain  <= remain - LEN_WIDTH'(1);
                        beats   <= beats - LEN_WIDTH'(1);
                        if (beats == LEN_WIDTH'(1)) begin
                            wrq     <= 1'b0;
                            rrq     <= 1'b0;
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_COUNT - 1)) begin
                        gap_cnt <= '0;
                        if (remain != '0) begin
                            beats   <= burst_len(remain);
                            mem_adr <= cur_adr;
                            wrq     <= we;
                            rrq     <= !we;
                            state   <= ST_BURST;
                        end else begin
                            done  <= grant;
                            grant <= '0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are gated by the live request so trailing beats are dropped.
    assign ch_wack_o   = wrq ? (grant & {NCHAN{mem_ready_i}}) : '0;
    assign ch_rvalid_o = rrq ? (grant & {NCHAN{mem_valid_i}}) : '0;
    assign ch_rdat_o   = rrq ? mem_dat_i : '0;
    assign ch_grant_o  = grant;
    assign ch_done_o   = done;
    assign mem_adr_o   = mem_adr;
    assign mem_dat_o   = cur_wdat;
    assign mem_mask_o  = cur_wmask;
    assign mem_wrq_o   = wrq;
    assign mem_rrq_o   = rrq;

endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// Directed + randomized bench for hyperbus_burst_ctrl; expected burst lists come
// from plain address/length arithmetic.
module tb_hyperbus_burst_ctrl;

    localparam int WIDTH       = 8;
    localparam int ADDR_LENGTH = 32;
    localparam int NCHAN       = 2;
    localparam int LEN_WIDTH   = 8;
    localparam int MAX_BURST   = 64;
    localparam int GAP_COUNT   = 3;
    localparam int WW          = 2 * WIDTH;
    localparam int MW          = 2 * WIDTH / 8;
`ifdef HBUS_CSM_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NCHAN-1:0]              ch_req_i;
    logic [NCHAN-1:0]              ch_we_i;
    logic [NCHAN*ADDR_LENGTH-1:0]  ch_adr_i;
    logic [NCHAN*LEN_WIDTH-1:0]    ch_len_i;
    logic [NCHAN*WW-1:0]           ch_wdat_i;
    logic [NCHAN*MW-1:0]           ch_wmask_i;
    logic [NCHAN-1:0]              ch_grant_o;
    logic [NCHAN-1:0]              ch_wack_o;
    logic [WW-1:0]                 ch_rdat_o;
    logic [NCHAN-1:0]              ch_rvalid_o;
    logic [NCHAN-1:0]              ch_done_o;
    logic [ADDR_LENGTH-1:0]        mem_adr_o;
    logic [WW-1:0]                 mem_dat_o;
    logic [MW-1:0]                 mem_mask_o;
    logic [WW-1:0]                 mem_dat_i;
    logic                          mem_ready_i;
    logic                          mem_valid_i;
    logic                          mem_wrq_o;
    logic                          mem_rrq_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hyperbus_burst_ctrl #(
        .WIDTH(WIDTH), .ADDR_LENGTH(ADDR_LENGTH), .NCHAN(NCHAN),
        .LEN_WIDTH(LEN_WIDTH), .MAX_BURST(MAX_BURST), .GAP_COUNT(GAP_COUNT)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_req_i(ch_req_i), .ch_we_i(ch_we_i), .ch_adr_i(ch_adr_i),
        .ch_len_i(ch_len_i), .ch_wdat_i(ch_wdat_i), .ch_wmask_i(ch_wmask_i),
        .ch_grant_o(ch_grant_o), .ch_wack_o(ch_wack_o), .ch_rdat_o(ch_rdat_o),
        .ch_rvalid_o(ch_rvalid_o), .ch_done_o(ch_done_o),
        .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_mask_o(mem_mask_o),
        .mem_dat_i(mem_dat_i), .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i),
        .mem_wrq_o(mem_wrq_o), .mem_rrq_o(mem_rrq_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rnd);
        mem_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        mem_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        mem_dat_i   = WW'($urandom);
        for (int c = 0; c < NCHAN; c++) begin
            ch_wdat_i[c*WW +: WW]  = WW'($urandom);
            ch_wmask_i[c*MW +: MW] = MW'($urandom);
        end
    endtask

    // One clock: inputs change 1 time unit after the edge, outputs sampled 1 later.
    task automatic step(input bit rnd);
        @(posedge clk);
        #1;
        drive(rnd);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},  ch_grant_o,  '0);
        check({tag, "_wack"},   ch_wack_o,   '0);
        check({tag, "_rvalid"}, ch_rvalid_o, '0);
        check({tag, "_rdat"},   ch_rdat_o,   '0);
        check({tag, "_done"},   ch_done_o,   '0);
        check({tag, "_adr"},    mem_adr_o,   '0);
        check({tag, "_dat"},    mem_dat_o,   '0);
        check({tag, "_mask"},   mem_mask_o,  '0);
        check({tag, "_rq"},     {mem_wrq_o, mem_rrq_o}, 2'b00);
    endtask

    task automatic do_xfer(input int ch, input bit we, input logic [31:0] adr,
                           input int len, input bit rnd);
        logic [31:0] eadr[$];
        int          elen[$];
        logic [31:0] a;
        int          rem, n, bi, beat_cnt, idle_cnt, cyc;
        bit          prev_rq, rq, fin;
        a   = adr;
        rem = len;
        while (rem > 0) begin
            n = (SPLIT && rem > MAX_BURST) ? MAX_BURST : rem;
            eadr.push_back(a);
            elen.push_back(n);
            a   = a + 32'(n);
            rem = rem - n;
        end
        step(rnd);
        ch_req_i[ch] = 1'b1;
        ch_we_i[ch]  = we;
        ch_adr_i[ch*ADDR_LENGTH +: ADDR_LENGTH] = adr;
        ch_len_i[ch*LEN_WIDTH +: LEN_WIDTH]     = LEN_WIDTH'(len);
        step(rnd);
        check("req_to_grant", ch_grant_o, 64'(1 << ch));
        bi = 0; beat_cnt = 0; idle_cnt = 0; cyc = 0; prev_rq = 0; fin = 0;
        while (!fin) begin
            rq = mem_wrq_o | mem_rrq_o;
            if (ch_done_o != '0) begin
                check("done_onehot", ch_done_o, 64'(1 << ch));
                check("done_grant_clr", ch_grant_o, '0);
                check("done_bursts", bi, eadr.size());
                check("done_latency", idle_cnt, (len == 0) ? 1 : GAP_COUNT);
                check("done_rq", rq, 0);
                ch_req_i[ch] = 1'b0;
                fin = 1;
            end else begin
                check("grant_hold", ch_grant_o, 64'(1 << ch));
                if (rq) begin
                    check("direction", {mem_wrq_o, mem_rrq_o}, we ? 2'b10 : 2'b01);
                    if (!prev_rq) begin
                        check("burst_gap", idle_cnt, (bi == 0) ? 0 : GAP_COUNT);
                        check("burst_adr", mem_adr_o, (bi < eadr.size()) ? eadr[bi] : 32'hDEAD_BEEF);
                        beat_cnt = 0;
                    end
                    check("wack", ch_wack_o, (we && mem_ready_i) ? 64'(1 << ch) : 64'd0);
                    check("rvalid", ch_rvalid_o, (!we && mem_valid_i) ? 64'(1 << ch) : 64'd0);
                    if (we) begin
                        check("wdat", mem_dat_o, ch_wdat_i[ch*WW +: WW]);
                        check("wmask", mem_mask_o, ch_wmask_i[ch*MW +: MW]);
                        beat_cnt += int'(mem_ready_i);
                    end else begin
                        if (mem_valid_i) check("rdat", ch_rdat_o, mem_dat_i);
                        beat_cnt += int'(mem_valid_i);
                    end
                end else begin
                    check("idle_no_beat", {ch_wack_o, ch_rvalid_o}, '0);
                    if (prev_rq) begin
                        check("burst_len", beat_cnt, (bi < elen.size()) ? elen[bi] : -1);
                        bi++;
                        idle_cnt = 1;
                    end else begin
                        idle_cnt++;
                    end
                end
                cyc++;
                if (cyc > 3000) begin
                    check("xfer_timeout", ch_done_o, 64'(1 << ch));
                    ch_req_i[ch] = 1'b0;
                    fin = 1;
                end
                prev_rq = rq;
                if (!fin) step(rnd);
            end
        end
    endtask

    initial begin
        int gseq[4];
        int ng, cyc, first_cyc, nb;
        logic [NCHAN-1:0] prev_g;
        logic [31:0] radr;

        rst = 1'b1;
        ch_req_i = '0; ch_we_i = '0; ch_adr_i = '0; ch_len_i = '0;
        ch_wdat_i = '0; ch_wmask_i = '0;
        mem_dat_i = 16'hA5A5; mem_ready_i = 1'b1; mem_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_all_zero("reset_val");

        // Simultaneous requests held continuously: 0 first, then alternating.
        step(0);
        ch_req_i = 2'b11;
        ch_we_i  = 2'b11;
        ch_adr_i = {32'h0000_2000, 32'h0000_1000};
        ch_len_i = {8'd2, 8'd2};
        prev_g = '0; ng = 0; cyc = 0; first_cyc = -1;
        while (ng < 4 && cyc < 200) begin
            step(0);
            cyc++;
            if (ch_grant_o != '0 && prev_g == '0) begin
                gseq[ng] = (ch_grant_o == 2'b10) ? 1 : 0;
                if (ng == 0) first_cyc = cyc;
                ng++;
            end
            prev_g = ch_grant_o;
        end
        check("arb_grant_count", ng, 4);
        check("arb_first_latency", first_cyc, 1);
        check("arb_seq0", gseq[0], 0);
        check("arb_seq1", gseq[1], 1);
        check("arb_seq2", gseq[2], 0);
        check("arb_seq3", gseq[3], 1);
        ch_req_i = '0;
        cyc = 0;
        while (ch_done_o == '0 && cyc < 100) begin
            step(0);
            cyc++;
        end
        check("arb_last_done", ch_done_o, 2'b10);

        do_xfer(0, 1'b1, 32'h0000_0100, 4, 1'b0);
        do_xfer(0, 1'b0, 32'h0000_0000, 150, 1'b0);
        do_xfer(1, 1'b0, $urandom, 0, 1'b1);
        do_xfer(1, 1'b0, 32'hFFFF_FFF0, 100, 1'b1);

        // Reset in the middle of a 10-beat write.
        step(0);
        ch_req_i[0] = 1'b1;
        ch_we_i[0]  = 1'b1;
        ch_adr_i[0 +: ADDR_LENGTH] = 32'h0000_0300;
        ch_len_i[0 +: LEN_WIDTH]   = 8'd10;
        nb = 0; cyc = 0;
        while (nb < 3 && cyc < 50) begin
            step(0);
            if (ch_wack_o[0]) nb++;
            cyc++;
        end
        check("rst_pre_beats", nb, 3);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        ch_req_i = '0;
        repeat (3) begin
            step(0);
            check("rst_no_done", ch_done_o, '0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        do_xfer(0, 1'b1, 32'h0000_0400, 10, 1'b0);

        for (int k = 0; k < 12; k++) begin
            radr = $urandom;
            do_xfer(int'($urandom_range(0, NCHAN - 1)), 1'($urandom), radr,
                    int'($urandom_range(0, 200)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
